lfsr_prbs_checker: RTL and testbench
====================================

// Module: lfsr_prbs_checker
// PURPOSE
//  Receive-side PRBS checker for the LFSR pattern generator. It consumes a serial bit stream
//  and self-synchronises a local WIDTH-bit LFSR replica to that stream. Once locked, it
//  flags each bit that differs from the predicted sequence and counts those errors.
//  It sits at the far end of a serial link or loopback, after the generator's serial output.
// PARAMETERS
//  WIDTH     4        LFSR length in bits (>=2)
//  TAPS      4'b1100  feedback tap mask, must match the generator (default x^4+x^3+1, period 15)
//  LOCK_CNT  8        consecutive correct predictions required to declare lock (>=1)
//  LOSS_CNT  3        consecutive errors while locked that drop lock (>=1)
//  CNT_W     16       width of the saturating error counter
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high; returns the block to FILL with all state cleared
//  clear     in   1      synchronous; zeroes err_count only, lock state untouched
//  in_valid  in   1      in_bit is sampled on a clock edge only when this is 1
//  in_bit    in   1      received serial bit (generator output = LFSR MSB)
//  locked    out  1      1 while in LOCKED state
//  bit_err   out  1      one-cycle pulse: the last valid bit mismatched while LOCKED
//  lock_lost out  1      one-cycle pulse on the LOCKED->FILL transition
//  err_count out  CNT_W  number of mismatches seen while LOCKED; saturates at all-ones
// BEHAVIOUR
//  Register r[WIDTH-1:0] holds the last WIDTH bits, oldest in the MSB. pred = ^(r & TAPS).
//  All outputs are registered. Reset values: locked=0, bit_err=0, lock_lost=0, err_count=0,
//   r=0, all counters=0, state=FILL.
//  A cycle with in_valid=0 changes nothing except that bit_err and lock_lost return to 0.
//  FILL: on each valid bit, r <= {r[WIDTH-2:0],in_bit} and fill_cnt++. After WIDTH bits,
//   go to SYNC with match_cnt=0. No comparisons are made in this state.
//  SYNC: on each valid bit, compare in_bit with pred, then shift in_bit into r.
//   Match: match_cnt++. Mismatch: match_cnt <= 0.
//   If r==0 after the shift, match_cnt <= 0 (the all-zero lock-up state never locks).
//   When match_cnt reaches LOCK_CNT, go to LOCKED; locked=1 from the next edge.
//  LOCKED: on each valid bit, r <= {r[WIDTH-2:0],pred}. The replica free-runs, so line errors
//   do not corrupt it. If in_bit!=pred: bit_err=1 on the next cycle, err_count++ (saturating),
//   and loss_cnt++. A match resets loss_cnt to 0.
//   When loss_cnt reaches LOSS_CNT, go to FILL: fill_cnt=0, locked=0, lock_lost=1 for one
//   cycle. err_count is retained.
//  Latency: bit_err and locked are valid on the edge that samples the deciding bit
//   (visible 1 clock after that bit is presented).
//  Simultaneous clear and counted error: clear wins, so err_count=0.
//  Assertion of reset mid-stream, in any state, clears everything immediately; relock
//   requires WIDTH+LOCK_CNT valid bits.
// TESTING
//  1 Reset, then feed the clean generator stream (seed 4'b0001), in_valid=1 continuously:
//    locked rises after valid bit 12 (4 fill + 8 matches); err_count stays 0 over 100 bits.
//  2 Lock, then invert only bit 40: bit_err is high for exactly one cycle, err_count=1, locked
//    stays 1, and following bits produce no errors (replica is not corrupted).
//  3 Lock, then invert 3 consecutive bits: err_count=3, lock_lost pulses, locked=0.
//    Resume the clean stream: relock after 12 more valid bits.
//  4 Feed all zeros after reset: locked never rises in 200 bits; err_count=0.
//  5 Set CNT_W=4, lock, then invert every 4th bit: err_count sticks at 15 and does not wrap.
//    Assert clear with an error on the same edge: err_count=0.
//  6 Toggle in_valid randomly on the clean stream: same lock point counted in valid bits,
//    zero errors. Assert reset mid-LOCKED: all outputs 0 on the next sample.

Source files
------------

// File: rtl/lfsr_prbs_checker_if.sv
// Bundles the data-side signals of the PRBS checker into one interface.
// The bench or upstream logic uses the master modport. The checker uses the slave modport.
//   clear     : synchronous clear of the error counter
//   in_valid  : qualifies in_bit on a clock edge
//   in_bit    : received serial bit
//   locked    : checker is locked to the stream
//   bit_err   : one-cycle pulse for a mismatched bit while locked
//   lock_lost : one-cycle pulse when lock is dropped
//   err_count : saturating mismatch counter, CNT_W bits wide
interface lfsr_prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             clear;
  logic             in_valid;
  logic             in_bit;
  logic             locked;
  logic             bit_err;
  logic             lock_lost;
  logic [CNT_W-1:0] err_count;

  modport master (
    output clear, in_valid, in_bit,
    input  locked, bit_err, lock_lost, err_count
  );

  modport slave (
    input  clear, in_valid, in_bit,
    output locked, bit_err, lock_lost, err_count
  );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Receive-side PRBS checker. It self-synchronises a local LFSR replica to a serial
// bit stream. Once locked, it flags and counts every bit that differs from the
// predicted sequence. It drops lock after LOSS_CNT consecutive errors.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high; returns to FILL with all state cleared
//   bus   : slave modport of lfsr_prbs_checker_if
//           inputs:  clear, in_valid, in_bit
//           outputs: locked, bit_err, lock_lost, err_count
// All outputs come straight from registers.
module lfsr_prbs_checker #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1100,
  parameter int               LOCK_CNT = 8,
  parameter int               LOSS_CNT = 3,
  parameter int               CNT_W    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  lfsr_prbs_checker_if.slave   bus
);

  localparam int FW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

  localparam logic [FW-1:0] FILL_LAST  = FW'(WIDTH - 1);
  localparam logic [MW-1:0] LOCK_TGT   = MW'(LOCK_CNT);
  localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {
    FILL,
    SYNC,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    loss_q, loss_d;
  logic             locked_q, locked_d;
  logic             bit_err_q, bit_err_d;
  logic             lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic             pred;
  logic [WIDTH-1:0] shifted_in;
  logic [WIDTH-1:0] shifted_pred;

  // The next bit is predicted from the last WIDTH bits. The oldest bit sits in the MSB.
  assign pred         = ^(r_q & TAPS);
  assign shifted_in   = {r_q[WIDTH-2:0], bus.in_bit};
  assign shifted_pred = {r_q[WIDTH-2:0], pred};

  // State and datapath registers. The reset puts every register back to its idle value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      r_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      loss_q      <= '0;
      locked_q    <= 1'b0;
      bit_err_q   <= 1'b0;
      lock_lost_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      loss_q      <= loss_d;
      locked_q    <= locked_d;
      bit_err_q   <= bit_err_d;
      lock_lost_q <= lock_lost_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic. Nothing moves without in_valid, except that the pulse outputs fall.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_d      = fill_q;
    match_d     = match_q;
    loss_d      = loss_q;
    locked_d    = locked_q;
    bit_err_d   = 1'b0;
    lock_lost_d = 1'b0;
    err_d       = err_q;

    if (bus.in_valid) begin
      case (state_q)
        FILL: begin
          r_d = shifted_in;
          if (fill_q == FILL_LAST) begin
            state_d = SYNC;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        SYNC: begin
          r_d = shifted_in;
          // An all-zero history is the LFSR lock-up state, so it never counts toward lock.
          if ((bus.in_bit == pred) && (shifted_in != '0)) begin
            match_d = match_q + 1'b1;
          end else begin
            match_d = '0;
          end
          if (match_d == LOCK_TGT) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            match_d  = '0;
          end
        end

        LOCKED: begin
          // The replica free-runs on its own prediction, so line errors cannot corrupt it.
          r_d = shifted_pred;
          if (bus.in_bit != pred) begin
            bit_err_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            if (loss_q == LOSS_LAST) begin
              state_d     = FILL;
              fill_d      = '0;
              loss_d      = '0;
              locked_d    = 1'b0;
              lock_lost_d = 1'b1;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end else begin
            loss_d = '0;
          end
        end

        default: begin
          state_d = FILL;
        end
      endcase
    end

    // Clear takes priority over an error counted on the same edge.
    if (bus.clear) begin
      err_d = '0;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.bit_err   = bit_err_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Self-checking bench for lfsr_prbs_checker. Two instances run side by side on
// identical stimulus: one with a 16-bit error counter and one with a 4-bit error counter.
// A queue-based reference model predicts every output after every clock.
module tb_lfsr_prbs_checker;

  localparam int         WIDTH    = 4;
  localparam logic [3:0] TAPS_P   = 4'b1100;
  localparam int         LOCK_CNT = 8;
  localparam int         LOSS_CNT = 3;
  localparam int         M_FILL   = 0;
  localparam int         M_SYNC   = 1;
  localparam int         M_LOCKED = 2;

  logic clock;
  logic reset;

  lfsr_prbs_checker_if #(.CNT_W(16)) bus16();
  lfsr_prbs_checker_if #(.CNT_W(4))  bus4();

  lfsr_prbs_checker #(
    .WIDTH(WIDTH), .TAPS(TAPS_P), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus16.slave)
  );

  lfsr_prbs_checker #(
    .WIDTH(WIDTH), .TAPS(TAPS_P), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(4)
  ) dut4 (
    .clock(clock), .reset(reset), .bus(bus4.slave)
  );

  // Free-running clock with a 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model state
  int   mode;
  int   fill_n, match_n, loss_n;
  bit   hist[$];
  int   err16, err4;
  bit   exp_locked, exp_bit_err, exp_lock_lost;

  // Stimulus generator state and bookkeeping
  logic [3:0] gen_s;
  int         valid_count;

  // Compares one observed value with its expected value and counts the comparison.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Returns the value the stream should take next, derived from the tap recurrence over recent bits.
  function automatic bit modelPredict();
    bit p = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (TAPS_P[i]) p ^= hist[hist.size() - 1 - i];
    end
    return p;
  endfunction

  function automatic bit lastBitsZero();
    bit z = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (hist[hist.size() - 1 - i]) z = 1'b0;
    end
    return z;
  endfunction

  task automatic modelReset();
    mode = M_FILL;
    fill_n = 0; match_n = 0; loss_n = 0;
    hist.delete();
    err16 = 0; err4 = 0;
    exp_locked = 1'b0; exp_bit_err = 1'b0; exp_lock_lost = 1'b0;
    valid_count = 0;
  endtask

  task automatic modelStep(input bit v, input bit b, input bit c);
    bit p;
    exp_bit_err = 1'b0;
    exp_lock_lost = 1'b0;
    if (v) begin
      if (mode == M_FILL) begin
        hist.push_back(b);
        fill_n++;
        if (fill_n == WIDTH) begin
          mode = M_SYNC;
          match_n = 0;
        end
      end else if (mode == M_SYNC) begin
        p = modelPredict();
        hist.push_back(b);
        match_n = (b == p) ? match_n + 1 : 0;
        if (lastBitsZero()) match_n = 0;
        if (match_n == LOCK_CNT) begin
          mode = M_LOCKED;
          exp_locked = 1'b1;
        end
      end else begin
        p = modelPredict();
        hist.push_back(p);
        if (b != p) begin
          exp_bit_err = 1'b1;
          if (err16 < 65535) err16++;
          if (err4 < 15) err4++;
          loss_n++;
          if (loss_n == LOSS_CNT) begin
            mode = M_FILL;
            fill_n = 0;
            loss_n = 0;
            exp_locked = 1'b0;
            exp_lock_lost = 1'b1;
          end
        end else begin
          loss_n = 0;
        end
      end
      while (hist.size() > WIDTH) hist.delete(0);
    end
    if (c) begin
      err16 = 0;
      err4 = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("locked",     int'(bus16.locked),    int'(exp_locked));
    checkOutput("bit_err",    int'(bus16.bit_err),   int'(exp_bit_err));
    checkOutput("lock_lost",  int'(bus16.lock_lost), int'(exp_lock_lost));
    checkOutput("err_count",  int'(bus16.err_count), err16);
    checkOutput("locked4",    int'(bus4.locked),     int'(exp_locked));
    checkOutput("bit_err4",   int'(bus4.bit_err),    int'(exp_bit_err));
    checkOutput("err_count4", int'(bus4.err_count),  err4);
  endtask

  // Drives one cycle of inputs to both instances from a falling edge.
  // The model is advanced on the rising edge, and the outputs are checked on the next falling edge.
  task automatic applyStimulus(input bit v, input bit b, input bit c);
    bus16.in_valid = v; bus16.in_bit = b; bus16.clear = c;
    bus4.in_valid  = v; bus4.in_bit  = b; bus4.clear  = c;
    @(posedge clock);
    modelStep(v, b, c);
    if (v) valid_count++;
    @(negedge clock);
    checkAll();
  endtask

  // Sends the next generator bit, optionally inverted. An invalid cycle sends junk and does not advance the generator.
  task automatic sendBit(input bit v, input bit flip, input bit c);
    bit b;
    if (v) begin
      b = gen_s[3] ^ flip;
      gen_s = {gen_s[2:0], ^(gen_s & TAPS_P)};
    end else begin
      b = 1'($urandom);
    end
    applyStimulus(v, b, c);
  endtask

  task automatic doReset(input bit reseed);
    reset = 1'b1;
    modelReset();
    #1;
    checkAll();
    @(negedge clock);
    reset = 1'b0;
    if (reseed) gen_s = 4'b0001;
  endtask

  int  lock_at;
  int  err_pulses;
  int  base;
  bit  seen_lost;
  bit  ever_locked;
  int  burst;
  int  garbage;

  initial begin
    reset = 1'b0;
    gen_s = 4'b0001;
    bus16.in_valid = 1'b0; bus16.in_bit = 1'b0; bus16.clear = 1'b0;
    bus4.in_valid  = 1'b0; bus4.in_bit  = 1'b0; bus4.clear  = 1'b0;
    modelReset();
    @(negedge clock);

    // Clean stream: lock after 4 fill bits plus 8 matches, with no errors.
    doReset(1'b1);
    lock_at = -1;
    for (int i = 0; i < 100; i++) begin
      sendBit(1'b1, 1'b0, 1'b0);
      if (lock_at < 0 && bus16.locked) lock_at = valid_count;
    end
    checkOutput("lock_point", lock_at, 12);
    checkOutput("clean_errs", int'(bus16.err_count), 0);

    // A single inverted bit gives one error, keeps lock, and leaves the replica intact.
    doReset(1'b1);
    err_pulses = 0;
    for (int i = 1; i <= 70; i++) begin
      sendBit(1'b1, (i == 40), 1'b0);
      if (bus16.bit_err) err_pulses++;
    end
    checkOutput("single_pulses", err_pulses, 1);
    checkOutput("single_errs", int'(bus16.err_count), 1);
    checkOutput("single_locked", int'(bus16.locked), 1);

    // Three consecutive errors drop lock, then the clean stream relocks in 12 bits.
    doReset(1'b1);
    seen_lost = 1'b0;
    for (int i = 1; i <= 20; i++) sendBit(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sendBit(1'b1, 1'b1, 1'b0);
      if (bus16.lock_lost) seen_lost = 1'b1;
    end
    checkOutput("burst_lost", int'(seen_lost), 1);
    checkOutput("burst_locked", int'(bus16.locked), 0);
    checkOutput("burst_errs", int'(bus16.err_count), 3);
    base = valid_count;
    lock_at = -1;
    for (int i = 0; i < 60 && lock_at < 0; i++) begin
      sendBit(1'b1, 1'b0, 1'b0);
      if (bus16.locked) lock_at = valid_count - base;
    end
    checkOutput("relock_point", lock_at, 12);

    // All-zero input must never lock.
    doReset(1'b1);
    ever_locked = 1'b0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (bus16.locked) ever_locked = 1'b1;
    end
    checkOutput("zeros_locked", int'(ever_locked), 0);
    checkOutput("zeros_errs", int'(bus16.err_count), 0);

    // Every 4th bit inverted: the 4-bit counter saturates at 15, then clear wins over an error.
    doReset(1'b1);
    for (int i = 1; i <= 20; i++) sendBit(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 80; i++) sendBit(1'b1, (i % 4 == 0), 1'b0);
    checkOutput("sat_count4", int'(bus4.err_count), 15);
    checkOutput("sat_count16", int'(bus16.err_count), 20);
    sendBit(1'b1, 1'b1, 1'b1);
    checkOutput("clear_err_pulse", int'(bus16.bit_err), 1);
    checkOutput("clear_wins", int'(bus4.err_count), 0);

    // Random valid gaps: the lock point is still 12 valid bits. Then reset asynchronously while locked.
    doReset(1'b1);
    lock_at = -1;
    for (int i = 0; i < 400 && lock_at < 0; i++) begin
      sendBit(($urandom_range(0, 2) != 0), 1'b0, 1'b0);
      if (bus16.locked) lock_at = valid_count;
    end
    checkOutput("gap_lock_point", lock_at, 12);
    for (int i = 0; i < 30; i++) sendBit(($urandom_range(0, 1) != 0), 1'b0, 1'b0);
    checkOutput("gap_errs", int'(bus16.err_count), 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkAll();
    @(negedge clock);
    checkAll();
    reset = 1'b0;

    // Random soak with gaps, sparse errors, bursts, junk stretches and clears.
    burst = 0;
    garbage = 0;
    for (int i = 0; i < 1500; i++) begin
      bit v, f, c;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      if (burst == 0 && $urandom_range(0, 99) == 0) burst = 3;
      if (garbage == 0 && $urandom_range(0, 399) == 0) garbage = 30;
      f = ($urandom_range(0, 19) == 0);
      if (burst > 0) begin f = 1'b1; if (v) burst--; end
      if (garbage > 0) begin f = 1'($urandom); garbage--; end
      sendBit(v, f, c);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
